// File: rtl/sqrt_pkg.sv
// ---------------------------------------------------------------------------
// sqrt_pkg
// Shared definitions for the FP16 square-root request scheduler:
//   - FP16 special-value constants
//   - scheduler state encoding
//   - operand class encoding produced by fp16_classify
// ---------------------------------------------------------------------------
package sqrt_pkg;

    localparam logic [15:0] FP16_QNAN = 16'h7E00;
    localparam logic [15:0] FP16_PINF = 16'h7C00;
    localparam logic [4:0]  EXP_MAX   = 5'h1F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        CLS_NAN  = 3'd0,
        CLS_PINF = 3'd1,
        CLS_NINF = 3'd2,
        CLS_ZERO = 3'd3,
        CLS_NEG  = 3'd4,
        CLS_NORM = 3'd5
    } class_t;

endpackage

// File: rtl/fp16_classify.sv
// ---------------------------------------------------------------------------
// fp16_classify
// Combinational FP16 operand classifier for the square-root scheduler.
// Every class except CLS_NORM has a fully determined square root, returned
// on o_result; for CLS_NORM o_result is 0 and the operand goes to the core.
//
// Ports:
//   i_op     in  16  FP16 operand {sign, exp[4:0], mant[9:0]}
//   o_class  out  3  operand class (class_t)
//   o_result out 16  special-case square root (0 for CLS_NORM)
// ---------------------------------------------------------------------------
module fp16_classify
    import sqrt_pkg::*;
(
    input  logic [15:0] i_op,
    output class_t      o_class,
    output logic [15:0] o_result
);

    logic       w_sign;
    logic [4:0] w_exp;
    logic [9:0] w_mant;

    assign w_sign = i_op[15];
    assign w_exp  = i_op[14:10];
    assign w_mant = i_op[9:0];

    always_comb begin
        o_class  = CLS_NORM;
        o_result = 16'h0000;
        if (w_exp == EXP_MAX) begin
            if (w_mant != 10'd0) begin
                o_class  = CLS_NAN;
                o_result = FP16_QNAN;
            end else if (w_sign) begin
                o_class  = CLS_NINF;
                o_result = FP16_QNAN;
            end else begin
                o_class  = CLS_PINF;
                o_result = FP16_PINF;
            end
        end else if ((w_exp == 5'd0) && (w_mant == 10'd0)) begin
            // sqrt(+0) = +0, sqrt(-0) = -0
            o_class  = CLS_ZERO;
            o_result = {w_sign, 15'd0};
        end else if (w_sign) begin
            // negative normal or subnormal
            o_class  = CLS_NEG;
            o_result = FP16_QNAN;
        end
    end

endmodule

// File: rtl/sqrt_sched.sv
// ---------------------------------------------------------------------------
// sqrt_sched
// Round-robin scheduler/sequencer in front of the shared iterative FP16
// square-root core. Accepts one request at a time, answers special operands
// directly and issues everything else to the core.
//
// Optional feature macro: SQRT_SCHED_TIMEOUT_EN (WAIT-state watchdog that
// forces a QNaN result with res_err after TIMEOUT_CYCLES WAIT cycles).
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req0_valid/ready/data[16]  requester 0 handshake + operand
//   req1_valid/ready/data[16]  requester 1 handshake + operand
//   core_start                 one-cycle issue pulse to the core
//   core_op[16]                operand to the core, held until core_done
//   core_done, core_result[16] core completion and result
//   res_valid/res_ready        result handshake
//   res_data[16]               FP16 result
//   res_id                     owning requester
//   res_special                result came from the special-case path
//   res_err                    watchdog expired
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; ready is granted combinationally
// ISSUE | core_start pulse with the latched operand
// WAIT  | waiting for core_done (or watchdog expiry)
// RESP  | res_valid high, result held until res_ready
// ---------------------------------------------------------------------------
module sqrt_sched
    import sqrt_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_data,
    output logic        core_start,
    output logic [15:0] core_op,
    input  logic        core_done,
    input  logic [15:0] core_result,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_id,
    output logic        res_special,
    output logic        res_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("sqrt_sched: TIMEOUT_CYCLES must be at least 1");
    end

    state_t      r_state;
    state_t      w_next;
    logic        r_last_grant;
    logic        r_id;
    logic [15:0] r_op;
    logic [15:0] r_res;
    class_t      r_class;

    logic        w_grant0;
    logic        w_grant1;
    logic        w_accept;
    logic [15:0] w_sel_op;
    class_t      w_class;
    logic [15:0] w_spec_res;
    logic        w_done;
    logic        w_expire;

    // Single valid wins outright; on contention the requester that did not
    // win last time gets the grant.
    assign w_grant0 = req0_valid & (~req1_valid | r_last_grant);
    assign w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);
    assign w_sel_op = w_grant1 ? req1_data : req0_data;
    assign w_accept = (r_state == ST_IDLE) & (req0_valid | req1_valid);
    assign w_done   = (r_state == ST_WAIT) & core_done;

    fp16_classify u_classify (
        .i_op     (w_sel_op),
        .o_class  (w_class),
        .o_result (w_spec_res)
    );

`ifdef SQRT_SCHED_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;

    // Expiry on the TIMEOUT_CYCLES-th WAIT cycle; a simultaneous core_done wins.
    assign w_expire = (r_state == ST_WAIT) & ~core_done &
                      (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_WAIT) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (w_expire) begin
            r_err <= 1'b1;
        end
    end

    assign res_err = r_err;
`else
    assign w_expire = 1'b0;
    assign res_err  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = (w_class == CLS_NORM) ? ST_ISSUE : ST_RESP;
                end
            end
            ST_ISSUE: w_next = ST_WAIT;
            ST_WAIT: begin
                if (w_done || w_expire) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (res_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        core_start = 1'b0;
        res_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req0_ready = w_grant0;
                req1_ready = w_grant1;
            end
            ST_ISSUE: core_start = 1'b1;
            ST_RESP:  res_valid  = 1'b1;
            default: ;
        endcase
    end

    // Request/result datapath. For normal operands w_spec_res is 0, so the
    // result register stays 0 until the core answers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_op         <= 16'h0000;
            r_res        <= 16'h0000;
            r_class      <= CLS_NORM;
        end else if (w_accept) begin
            r_last_grant <= w_grant1;
            r_id         <= w_grant1;
            r_op         <= w_sel_op;
            r_res        <= w_spec_res;
            r_class      <= w_class;
        end else if (w_done) begin
            r_res        <= core_result;
        end else if (w_expire) begin
            r_res        <= FP16_QNAN;
        end
    end

    assign core_op     = r_op;
    assign res_data    = r_res;
    assign res_id      = r_id;
    assign res_special = (r_class != CLS_NORM);

endmodule

// File: tb/tb_sqrt_sched.sv
// ---------------------------------------------------------------------------
// tb_sqrt_sched
// Self-checking bench for sqrt_sched. A behavioural core answers each
// core_start after a programmable latency; expected results come from the
// FP16 square-root special-case rules and a round-robin grant model.
// ---------------------------------------------------------------------------
module tb_sqrt_sched;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0;
    logic        req0_ready;
    logic [15:0] req0_data = 16'h0000;
    logic        req1_valid = 1'b0;
    logic        req1_ready;
    logic [15:0] req1_data = 16'h0000;
    logic        core_start;
    logic [15:0] core_op;
    logic        core_done = 1'b0;
    logic [15:0] core_result = 16'h0000;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic        res_id;
    logic        res_special;
    logic        res_err;

    int          n_cmp = 0;
    int          n_fail = 0;

    int          n_start = 0;
    int          core_cnt = 0;
    int          core_lat = 2;
    bit          core_mute = 1'b0;
    bit          inject_done = 1'b0;
    logic [15:0] core_next = 16'h0000;
    logic        model_last = 1'b1;

    always #5 clk = ~clk;

    sqrt_sched #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_data   (req0_data),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_data   (req1_data),
        .core_start  (core_start),
        .core_op     (core_op),
        .core_done   (core_done),
        .core_result (core_result),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_id      (res_id),
        .res_special (res_special),
        .res_err     (res_err)
    );

    // Behavioural core: done pulse core_lat cycles after the start cycle.
    always @(negedge clk) begin
        core_done = 1'b0;
        if (!rst_n) begin
            core_cnt = 0;
        end else if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0 && !core_mute) begin
                core_done   = 1'b1;
                core_result = core_next;
            end
        end
        if (inject_done) core_done = 1'b1;
        if (core_start) begin
            n_start++;
            core_cnt = core_lat;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
        $fatal(1, "global timeout");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Returns {is_special, result} from the IEEE sqrt special-case rules.
    function automatic logic [16:0] ref_special(input logic [15:0] x);
        logic       s;
        logic [4:0] e;
        logic [9:0] m;
        s = x[15];
        e = x[14:10];
        m = x[9:0];
        if (e == 5'd31) begin
            if (m != 0) return {1'b1, 16'h7E00};
            return s ? {1'b1, 16'h7E00} : {1'b1, 16'h7C00};
        end
        if (e == 5'd0 && m == 10'd0) return {1'b1, x};
        if (s) return {1'b1, 16'h7E00};
        return {1'b0, 16'h0000};
    endfunction

    function automatic logic [15:0] rand_op();
        logic [15:0] specials [9];
        logic [4:0]  e;
        specials = '{16'h7C00, 16'hFC00, 16'h0000, 16'h8000, 16'h7E01,
                     16'hFE00, 16'h7C01, 16'hBC00, 16'h8001};
        e = 5'($urandom_range(1, 30));
        case ($urandom_range(0, 5))
            0: return specials[$urandom_range(0, 8)];
            1: return {1'b0, e, 10'($urandom)};
            2: return 16'($urandom);
            3: return {6'b0, 10'($urandom_range(1, 1023))};
            4: return {1'b1, e, 10'($urandom)};
            default: return {1'b0, 15'($urandom)};
        endcase
    endfunction

    // One complete request/response transaction with full checking.
    task automatic do_txn(input string nm, input logic v0, input logic v1,
                          input logic [15:0] d0, input logic [15:0] d1,
                          input int lat, input bit mute, input int hold,
                          input logic [15:0] cval);
        logic        win;
        logic [15:0] op;
        logic [16:0] sp;
        logic [15:0] exp_data;
        logic        exp_err;
        int          exp_k;
        int          k;
        int          starts0;

        win = (v0 && v1) ? ~model_last : v1;
        op  = win ? d1 : d0;
        sp  = ref_special(op);
        core_lat  = lat;
        core_mute = mute;
        core_next = cval;
        exp_err   = 1'b0;
        if (sp[16]) begin
            exp_k    = 1;
            exp_data = sp[15:0];
        end else begin
            exp_k    = lat + 2;
            exp_data = cval;
`ifdef SQRT_SCHED_TIMEOUT_EN
            if (mute || lat > TO) begin
                exp_k    = TO + 2;
                exp_data = 16'h7E00;
                exp_err  = 1'b1;
            end
`endif
        end

        req0_valid = v0; req1_valid = v1;
        req0_data  = d0; req1_data  = d1;
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== {v0 && !win, v1 && win}) begin
            n_fail++;
            $display("FAIL %s grant: ready=%b required %b", nm,
                     {req0_ready, req1_ready}, {v0 && !win, v1 && win});
        end
        starts0 = n_start;
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;

        k = 1;
        while (res_valid !== 1'b1 && k < 200) begin
            step();
            k++;
        end
        n_cmp++;
        if (res_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s res_valid_timeout: waited %0d cycles, required res_valid", nm, k);
            return;
        end
        n_cmp++;
        if (k != exp_k) begin
            n_fail++;
            $display("FAIL %s latency: %0d cycles, required %0d", nm, k, exp_k);
        end
        n_cmp++;
        if ({res_data, res_id, res_special, res_err} !== {exp_data, win, sp[16], exp_err}) begin
            n_fail++;
            $display("FAIL %s result: data=%h id=%b sp=%b err=%b required data=%h id=%b sp=%b err=%b",
                     nm, res_data, res_id, res_special, res_err, exp_data, win, sp[16], exp_err);
        end
        n_cmp++;
        if (n_start - starts0 != (sp[16] ? 0 : 1)) begin
            n_fail++;
            $display("FAIL %s core_starts: %0d, required %0d", nm, n_start - starts0, sp[16] ? 0 : 1);
        end

        for (int i = 0; i < hold; i++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            req0_data = 16'($urandom); req1_data = 16'($urandom);
            step();
            n_cmp++;
            if ({res_valid, res_data, res_id, res_special, res_err, req0_ready, req1_ready}
                !== {1'b1, exp_data, win, sp[16], exp_err, 2'b00}) begin
                n_fail++;
                $display("FAIL %s stall: valid=%b data=%h id=%b ready=%b%b required valid=1 data=%h id=%b ready=00",
                         nm, res_valid, res_data, res_id, req0_ready, req1_ready, exp_data, win);
            end
            n_cmp++;
            if (n_start - starts0 != (sp[16] ? 0 : 1)) begin
                n_fail++;
                $display("FAIL %s stall_starts: %0d, required %0d", nm, n_start - starts0, sp[16] ? 0 : 1);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        n_cmp++;
        if (res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s release: res_valid=%b required 0", nm, res_valid);
        end
        model_last = win;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        n_cmp++;
        if ({req0_ready, req1_ready, core_start, core_op, res_valid, res_data,
             res_id, res_special, res_err} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: op=%h data=%h valid=%b start=%b required all 0",
                     core_op, res_data, res_valid, core_start);
        end
        rst_n = 1'b1;
        model_last = 1'b1;
        step();
    endtask

    task automatic test_normal();
        do_txn("normal_4p0", 1'b1, 1'b0, 16'h4400, 16'h0000, 2, 1'b0, 0, 16'h4000);
        do_txn("normal_r1", 1'b0, 1'b1, 16'h0000, 16'h3C00, 1, 1'b0, 0, 16'h3C00);
    endtask

    task automatic test_arbitration();
        test_reset();
        for (int i = 0; i < 4; i++) begin
            do_txn("arb", 1'b1, 1'b1, 16'h7C00, 16'hFC00, 1, 1'b0, 0, 16'h0000);
        end
    endtask

    task automatic test_special();
        do_txn("neg_zero", 1'b0, 1'b1, 16'h0000, 16'h8000, 1, 1'b0, 0, 16'h1111);
        do_txn("neg_one", 1'b0, 1'b1, 16'h0000, 16'hBC00, 1, 1'b0, 0, 16'h1111);
        do_txn("nan", 1'b1, 1'b0, 16'h7D55, 16'h0000, 1, 1'b0, 0, 16'h1111);
        do_txn("pos_zero", 1'b1, 1'b0, 16'h0000, 16'h0000, 1, 1'b0, 0, 16'h1111);
        do_txn("pos_subn", 1'b1, 1'b0, 16'h0001, 16'h0000, 3, 1'b0, 0, 16'h0C00);
    endtask

    task automatic test_stall();
        do_txn("stall_norm", 1'b1, 1'b0, 16'h4400, 16'h0000, 2, 1'b0, 10, 16'h4000);
        do_txn("stall_spec", 1'b0, 1'b1, 16'h0000, 16'hFC00, 1, 1'b0, 10, 16'h0000);
    endtask

    task automatic test_reset_in_wait();
        core_mute = 1'b1;
        core_lat  = 3;
        req0_valid = 1'b1; req0_data = 16'h3C00;
        step();
        req0_valid = 1'b0;
        step();
        step();
        n_cmp++;
        if ({core_op, res_valid} !== {16'h3C00, 1'b0}) begin
            n_fail++;
            $display("FAIL wait_hold: core_op=%h res_valid=%b required 3c00/0", core_op, res_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready, core_start, core_op, res_valid, res_data,
             res_id, res_special, res_err} !== 38'd0) begin
            n_fail++;
            $display("FAIL async_reset: op=%h data=%h valid=%b start=%b required all 0",
                     core_op, res_data, res_valid, core_start);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        model_last = 1'b1;
        core_mute = 1'b0;
        inject_done = 1'b1;
        step();
        inject_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if ({res_valid, core_start} !== 2'b00) begin
                n_fail++;
                $display("FAIL stale_done: res_valid=%b core_start=%b required 00", res_valid, core_start);
            end
        end
    endtask

    task automatic test_wait_limit();
`ifdef SQRT_SCHED_TIMEOUT_EN
        do_txn("timeout", 1'b1, 1'b0, 16'h4400, 16'h0000, TO, 1'b1, 0, 16'h4000);
        do_txn("timeout_race", 1'b0, 1'b1, 16'h0000, 16'h4400, TO, 1'b0, 0, 16'h4000);
        do_txn("after_timeout", 1'b1, 1'b0, 16'h4400, 16'h0000, 2, 1'b0, 0, 16'h4000);
`else
        do_txn("long_wait", 1'b1, 1'b0, 16'h4400, 16'h0000, 40, 1'b0, 0, 16'h4000);
`endif
    endtask

    task automatic test_random();
        logic v0, v1;
        for (int i = 0; i < 40; i++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            do_txn("random", v0, v1, rand_op(), rand_op(), $urandom_range(1, 5),
                   1'b0, $urandom_range(0, 3), 16'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_arbitration();
        test_special();
        test_stall();
        test_reset_in_wait();
        test_wait_limit();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
